// File: rtl/serial_piso_feeder.sv
// LSB-first parallel-to-serial feeder with a one-entry holding buffer and an optional idle gap between words.
// First bit leaves two edges after acceptance; din_ready drops while the holding buffer is full.
module serial_piso_feeder #(
  parameter int BITS = 4,
  parameter int GAP  = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic            data,
  output logic            shift_en,
  output logic            done,
  output logic            busy
);

  localparam int            CW       = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP - 1);
  localparam bit            HAS_GAP  = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BITS-1:0] r_hold;
  logic [BITS-1:0] r_shifter;
  logic            r_hold_full;
  logic [CW-1:0]   r_bit_cnt;
  logic [7:0]      r_gap_cnt;
  logic            w_load;
  logic            w_accept;
  logic            w_last;
  logic            w_gap_end;

  assign w_accept  = din_valid & din_ready;
  assign w_last    = (r_bit_cnt == LAST_BIT);
  assign w_gap_end = (r_gap_cnt == GAP_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // w_load moves the held word into the shifter; it also frees the buffer for the next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (HAS_GAP) begin
            w_state_nxt = S_GAP;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shifter   <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_hold <= din;
      end
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end
      if (w_load) begin
        r_shifter <= r_hold;
        r_bit_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shifter <= r_shifter >> 1;
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 8'd1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign din_ready = ~r_hold_full & ~RST;
  assign shift_en  = (r_state == S_SHIFT);
  assign data      = shift_en & r_shifter[0];
  assign done      = shift_en & w_last;
  assign busy      = (r_state != S_IDLE) | r_hold_full;

endmodule
